// File: rtl/palindrome_bit_framer.sv
// Serial-to-parallel framer: packs MSB-first bits into Data_width-bit words on a
// registered valid/ready output, with start-of-frame realignment and fragment flagging.
module palindrome_bit_framer #(
  parameter int Data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  bit_sof,
  output logic                  bit_ready,
  output logic [Data_width-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  frag_err
);

  localparam int CNT_W = (Data_width > 2) ? $clog2(Data_width) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Data_width - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [Data_width-1:0] sh_reg, sh_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [Data_width-1:0] word_out_reg, word_out_next;
  logic                  word_valid_reg, word_valid_next;
  logic                  frag_err_reg, frag_err_next;

  logic [Data_width-1:0] sh_shifted;
  logic [Data_width-1:0] sh_sof;
  logic                  acc;
  logic                  take;

  // sh_shifted is the shift register with bit_in appended as the new LSB.
  assign sh_shifted[0] = bit_in;
  generate
    for (genvar gi = 1; gi < Data_width; gi++) begin : g_shift
      assign sh_shifted[gi] = sh_reg[gi-1];
    end
  endgenerate

  assign sh_sof    = {{(Data_width-1){1'b0}}, bit_in};
  assign bit_ready = ~word_valid_reg | word_ready;
  assign acc       = bit_valid & bit_ready;
  assign take      = word_valid_reg & word_ready;

  always_comb begin
    sh_next         = sh_reg;
    cnt_next        = cnt_reg;
    word_out_next   = word_out_reg;
    word_valid_next = word_valid_reg;
    frag_err_next   = 1'b0;

    if (take) begin
      word_valid_next = 1'b0;
    end

    // Completion is evaluated after take so a new word always wins the valid flag.
    if (acc) begin
      if (bit_sof) begin
        sh_next       = sh_sof;
        cnt_next      = CNT_ONE;
        frag_err_next = (cnt_reg != '0);
      end else if (cnt_reg == CNT_LAST) begin
        sh_next         = sh_shifted;
        cnt_next        = '0;
        word_out_next   = sh_shifted;
        word_valid_next = 1'b1;
      end else begin
        sh_next  = sh_shifted;
        cnt_next = cnt_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg         <= '0;
      cnt_reg        <= '0;
      word_out_reg   <= '0;
      word_valid_reg <= 1'b0;
      frag_err_reg   <= 1'b0;
    end else begin
      sh_reg         <= sh_next;
      cnt_reg        <= cnt_next;
      word_out_reg   <= word_out_next;
      word_valid_reg <= word_valid_next;
      frag_err_reg   <= frag_err_next;
    end
  end

  assign word_out   = word_out_reg;
  assign word_valid = word_valid_reg;
  assign frag_err   = frag_err_reg;

endmodule

// File: tb/tb_palindrome_bit_framer.sv
// Directed bench for palindrome_bit_framer: reset, single word, backpressure,
// streaming, realignment and reset mid-word, with hand-computed expectations.
module tb_palindrome_bit_framer;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_sof;
  logic       bit_ready;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       frag_err;

  int errors = 0;
  int checks = 0;
  int nfrag  = 0;
  int nwv    = 0;

  palindrome_bit_framer #(.Data_width(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_sof    (bit_sof),
    .bit_ready  (bit_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frag_err   (frag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one clock edge, then tally any frag/valid seen afterwards.
  task automatic send_bit(input logic b, input logic sof);
    bit_in    = b;
    bit_sof   = sof;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    if (frag_err)   nfrag++;
    if (word_valid) nwv++;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic sof_first);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], sof_first && (i == 7));
    end
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] stream;
    logic [7:0]  pat66;
    logic [7:0]  w0, w1;
    int          t0, t1, nw;

    rst_n      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    bit_sof    = 1'b0;
    word_ready = 1'b1;
    w0 = '0; w1 = '0; t0 = 0; t1 = 0; nw = 0;

    // 1. Reset
    @(posedge clk);
    #1;
    chk("rst_word_out",   word_out,   32'h00);
    chk("rst_word_valid", word_valid, 32'h0);
    chk("rst_frag_err",   frag_err,   32'h0);
    chk("rst_bit_ready",  bit_ready,  32'h1);
    rst_n = 1'b1;

    // 2. Single word 0x99
    nfrag = 0; nwv = 0;
    send_byte(8'h99, 1'b1);
    chk("single_valid",    word_valid, 32'h1);
    chk("single_word",     word_out,   32'h99);
    chk("single_no_early", nwv,        32'd1);
    chk("single_no_frag",  nfrag,      32'd0);
    idle();
    chk("single_one_cycle", word_valid, 32'h0);

    // 3. Backpressure on 0xA5; the held pending bit is the MSB of the next word
    word_ready = 1'b0;
    send_byte(8'hA5, 1'b1);
    bit_in = 1'b1; bit_sof = 1'b1; bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bit_ready",  bit_ready,  32'h0);
      chk("bp_word_out",   word_out,   32'hA5);
      chk("bp_word_valid", word_valid, 32'h1);
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    word_ready = 1'b1;
    #1;
    chk("bp_release_ready", bit_ready, 32'h1);
    @(posedge clk);
    #1;
    chk("bp_taken",      word_valid, 32'h0);
    chk("bp_frag_clear", frag_err,   32'h0);

    // 4. Streaming: remaining 7 bits of 0x81 then 0x3C, no gaps
    stream = {7'b0000001, 8'h3C};
    for (int i = 14; i >= 0; i--) begin
      chk("stream_bit_ready", bit_ready, 32'h1);
      send_bit(stream[i], 1'b0);
      if (word_valid) begin
        if (nw == 0) begin
          w0 = word_out; t0 = i;
        end else begin
          w1 = word_out; t1 = i;
        end
        nw++;
      end
    end
    chk("stream_count", nw,      32'd2);
    chk("stream_w0",    w0,      32'h81);
    chk("stream_w1",    w1,      32'h3C);
    chk("stream_gap",   t0 - t1, 32'd8);
    idle();

    // 5. Realign: 3-bit fragment discarded by a new sof
    nfrag = 0; nwv = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("realign_no_frag_yet", frag_err, 32'h0);
    send_bit(1'b0, 1'b1);
    chk("realign_frag_pulse", frag_err, 32'h1);
    pat66 = 8'h66;
    for (int i = 6; i >= 0; i--) begin
      send_bit(pat66[i], 1'b0);
    end
    chk("realign_valid",     word_valid, 32'h1);
    chk("realign_word",      word_out,   32'h66);
    chk("realign_frag_once", nfrag,      32'd1);
    chk("realign_one_word",  nwv,        32'd1);
    idle();

    // 6. Reset mid-word, then 0xF0 without sof
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midrst_async_valid", word_valid, 32'h0);
    chk("midrst_async_word",  word_out,   32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nfrag = 0; nwv = 0;
    send_byte(8'hF0, 1'b0);
    chk("midrst_valid",   word_valid, 32'h1);
    chk("midrst_word",    word_out,   32'hF0);
    chk("midrst_no_frag", nfrag,      32'd0);
    chk("midrst_one",     nwv,        32'd1);
    idle();
    chk("midrst_taken", word_valid, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
